// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - skewed-carry pipelined add/subtract unit with valid/ready handshake
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic             carry_in,
    input  logic             sub_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             carry_out,
    output logic             zero_out,
    output logic             overflow_out
);
    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
        $error("pipelined_adder: STAGES must be >= 1 and divide WIDTH evenly");
    end

    // The whole pipe moves as one; it only stalls when a finished result is not taken.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage k adds chunk k. Operand A travels full width and has its lower chunks
    // overwritten with sums as they complete; operand B only carries its still
    // unprocessed upper chunks, so it narrows by one chunk per stage.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int RW = WIDTH - k * CW;

        logic             src_v;
        logic [WIDTH-1:0] src_a;
        logic [RW-1:0]    src_b;
        logic             src_c;
        logic [CW:0]      chunk;
        logic [WIDTH-1:0] merged;
        logic             v_q;
        logic [WIDTH-1:0] a_q;
        logic             c_q;

        if (k == 0) begin : g_src
            assign src_v = in_valid;
            assign src_a = input_a;
            assign src_b = input_b ^ {WIDTH{sub_mode}};
            assign src_c = carry_in;
        end else begin : g_src
            assign src_v = g_stage[k-1].v_q;
            assign src_a = g_stage[k-1].a_q;
            assign src_b = g_stage[k-1].g_bq.b_q;
            assign src_c = g_stage[k-1].c_q;
        end

        assign chunk = {1'b0, src_a[k*CW +: CW]} + {1'b0, src_b[CW-1:0]} + {{CW{1'b0}}, src_c};

        // Splice this stage's chunk sum into the travelling A word.
        always_comb begin
            merged              = src_a;
            merged[k*CW +: CW]  = chunk[CW-1:0];
        end

        // Stage valid bit, partial sum and inter-chunk carry.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v_q <= 1'b0;
                a_q <= '0;
                c_q <= 1'b0;
            end else if (adv) begin
                v_q <= src_v;
                if (src_v) begin
                    a_q <= merged;
                    c_q <= chunk[CW];
                end
            end
        end

        if (k < LAST) begin : g_bq
            logic [RW-CW-1:0] b_q;

            // Unprocessed upper chunks of B move forward with the transaction.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    b_q <= '0;
                end else if (adv && src_v) begin
                    b_q <= src_b[RW-1:CW];
                end
            end
        end
    end

    // Flags need the fully assembled result, so they are formed in the final stage.
    // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
    logic fin_zero;
    logic fin_ovf;
    logic zero_q;
    logic ovf_q;

    assign fin_zero = (g_stage[LAST].merged == '0);
    assign fin_ovf  = g_stage[LAST].src_a[WIDTH-1] ^ g_stage[LAST].src_b[CW-1]
                    ^ g_stage[LAST].merged[WIDTH-1] ^ g_stage[LAST].chunk[CW];

    // Registered zero/overflow flags, updated alongside the last stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (adv && g_stage[LAST].src_v) begin
            zero_q <= fin_zero;
            ovf_q  <= fin_ovf;
        end
    end

    assign out_valid    = g_stage[LAST].v_q;
    assign out_result   = g_stage[LAST].a_q;
    assign carry_out    = g_stage[LAST].c_q;
    assign zero_out     = zero_q;
    assign overflow_out = ovf_q;

endmodule
